// File: rtl/tile_scan.sv
// Raster sequencer driving the edge-function tile: restart, then stepx/stepy over a w x h window,
// emitting one (x, y, hit) record per pixel. Define TILE_SCAN_HITONLY_EN to emit hit pixels only.
module tile_scan #(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [XW-1:0] cfg_w,
  input  logic [YW-1:0] cfg_h,
  output logic          busy,
  output logic          done,
  output logic [1:0]    command,
  input  logic          inside_triangle,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_hit,
  output logic          pix_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [1:0] CMD_NOP     = 2'd0;
  localparam logic [1:0] CMD_RESTART = 2'd1;
  localparam logic [1:0] CMD_STEPY   = 2'd2;
  localparam logic [1:0] CMD_STEPX   = 2'd3;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] w_q, w_d;
  logic [YW-1:0] h_q, h_d;
  logic          done_q, done_d;

  logic [1:0]    cmdRaw;
  logic          lastCol;
  logic          lastRow;
  logic          recValid;
  logic          advance;
  logic          lastQualifier;

  assign lastCol = (x_q == w_q - XW'(1));
  assign lastRow = (y_q == h_q - YW'(1));

`ifdef TILE_SCAN_HITONLY_EN
  // Misses are never offered downstream, so they step the tile without waiting for ready.
  assign recValid      = inside_triangle;
  assign advance       = pix_ready || !inside_triangle;
  assign lastQualifier = inside_triangle;
`else
  assign recValid      = 1'b1;
  assign advance       = pix_ready;
  assign lastQualifier = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    cmdRaw    = CMD_NOP;
    pix_valid = 1'b0;
    pix_last  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_w != '0) && (cfg_h != '0)) begin
            w_d     = cfg_w;
            h_d     = cfg_h;
            x_d     = '0;
            y_d     = '0;
            cmdRaw  = CMD_RESTART;
            state_d = SCAN;
          end else begin
            state_d = FIN;
          end
        end
      end

      SCAN: begin
        pix_valid = recValid;
        pix_last  = lastCol && lastRow && lastQualifier;
        if (advance) begin
          if (!lastCol) begin
            cmdRaw = CMD_STEPX;
            x_d    = x_q + XW'(1);
          end else if (!lastRow) begin
            // The tile returns to column 0 of the next row on stepy.
            cmdRaw = CMD_STEPY;
            x_d    = '0;
            y_d    = y_q + YW'(1);
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done_d = (state_d == FIN);

  // Gate with reset so a start held during reset can never leak a restart to the tile.
  assign command  = reset_n ? cmdRaw : CMD_NOP;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign pix_x    = x_q;
  assign pix_y    = y_q;
  assign pix_hit  = inside_triangle;

endmodule
